// File: rtl/mem_responder.sv
// 256x8 request/response memory: captures a request, idles WAIT_STATES cycles, then performs it;
// Ready pulses WAIT_STATES+1 cycles after capture; Mem_CS deasserted during WAIT aborts, no other backpressure.
module mem_responder #(
  parameter int WAIT_STATES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Mem_CS,
  input  logic       Mem_WR,
  input  logic [7:0] Address,
  input  logic [7:0] Data_In,
  output logic [7:0] Mem_Out,
  output logic       Ready,
  output logic       Busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [7:0] addr_q, data_q;
  logic       wr_q;
  logic       armed;
  logic       capture;
  logic       do_op;
  logic       op_wr;
  logic [7:0] op_addr, op_data;
  logic [7:0] mem [256];

  // armed is cleared asynchronously by reset, so nothing is captured or written
  // while reset is held or on the first edge after release.
  assign capture = (state == S_IDLE) && !Mem_CS && armed;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_op     = 1'b0;
    op_wr     = wr_q;
    op_addr   = addr_q;
    op_data   = data_q;
    case (state)
      S_IDLE: begin
        if (capture) begin
          if (WAIT_STATES == 0) begin
            // No wait phase: the capture edge is also the access edge, so use live inputs.
            state_nxt = S_ACCESS;
            do_op     = 1'b1;
            op_wr     = Mem_WR;
            op_addr   = Address;
            op_data   = Data_In;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (Mem_CS) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 3'd0;
        end else if (cnt == 3'd0) begin
          state_nxt = S_ACCESS;
          do_op     = 1'b1;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      S_ACCESS: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      wr_q    <= 1'b0;
      armed   <= 1'b0;
      Mem_Out <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      armed <= 1'b1;
      if (capture) begin
        addr_q <= Address;
        data_q <= Data_In;
        wr_q   <= Mem_WR;
      end
      if (do_op && !op_wr) Mem_Out <= mem[op_addr];
    end
  end

  // Storage survives reset by design.
  always_ff @(posedge Clock) begin
    if (do_op && op_wr) mem[op_addr] <= op_data;
  end

  assign Ready = (state == S_ACCESS);
  assign Busy  = (state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with WAIT_STATES=2, one with WAIT_STATES=0.
module tb_mem_responder;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       cs   [2];
  logic       wr   [2];
  logic [7:0] addr [2];
  logic [7:0] din  [2];
  logic [7:0] mout [2];
  logic       rdy  [2];
  logic       busy [2];

  always #5 Clock = ~Clock;

  mem_responder #(.WAIT_STATES(2)) dut (
    .Clock(Clock), .Reset(Reset), .Mem_CS(cs[0]), .Mem_WR(wr[0]), .Address(addr[0]),
    .Data_In(din[0]), .Mem_Out(mout[0]), .Ready(rdy[0]), .Busy(busy[0])
  );

  mem_responder #(.WAIT_STATES(0)) dut_ws0 (
    .Clock(Clock), .Reset(Reset), .Mem_CS(cs[1]), .Mem_WR(wr[1]), .Address(addr[1]),
    .Data_In(din[1]), .Mem_Out(mout[1]), .Ready(rdy[1]), .Busy(busy[1])
  );

  typedef struct {
    int         d;
    logic       is_rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb [$];
  exp_t       mon_e;
  logic [7:0] model [2][256];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         rdy_cyc  [2];
  int         prev_rdy [2];

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge Clock) cyc <= cyc + 1;

  // Ready is sampled on the falling edge; each pulse must match the oldest expectation.
  always @(negedge Clock) begin
    for (int d = 0; d < 2; d++) begin
      if (rdy[d] !== 1'b0) begin
        if (sb.size() == 0 || sb[0].d != d) begin
          chk("unexpected_ready", 32'(rdy[d]), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ready_cycle", cyc, mon_e.cyc);
          if (mon_e.is_rd) chk("read_data", 32'(mout[d]), 32'(mon_e.data));
          prev_rdy[d] = rdy_cyc[d];
          rdy_cyc[d]  = cyc;
        end
      end
    end
  end

  // Issue one request and follow it to its Ready cycle; hold keeps Mem_CS low for a back-to-back request.
  task automatic do_req(input int d, input logic w, input logic [7:0] a, input logic [7:0] dat,
                        input bit hold, input bit scramble);
    int         ws;
    exp_t       e;
    logic [7:0] mo_before;
    ws = ws_of(d);
    @(negedge Clock);
    cs[d] = 1'b0; wr[d] = w; addr[d] = a; din[d] = dat;
    e.d = d; e.is_rd = !w; e.data = w ? dat : model[d][a]; e.cyc = cyc + 1 + ws;
    if (w) model[d][a] = dat;
    sb.push_back(e);
    mo_before = mout[d];
    for (int i = 0; i <= ws; i++) begin
      @(negedge Clock);
      chk("busy_during_req", 32'(busy[d]), 32'd1);
      if (scramble && i == 0) begin
        addr[d] = a ^ 8'h01; wr[d] = !w; din[d] = ~dat;
      end
    end
    if (w) chk("write_keeps_mem_out", 32'(mout[d]), 32'(mo_before));
    if (!hold) cs[d] = 1'b1;
  endtask

  initial begin
    logic [7:0] ra, rd;
    logic       rw;
    for (int d = 0; d < 2; d++) begin
      cs[d] = 1'b1; wr[d] = 1'b0; addr[d] = 8'h00; din[d] = 8'h00;
      rdy_cyc[d] = 0; prev_rdy[d] = 0;
      for (int i = 0; i < 256; i++) model[d][i] = 8'h00;
    end
    Reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_mem_out", 32'(mout[d]), 32'h00);
      chk("reset_ready", 32'(rdy[d]), 32'd0);
      chk("reset_busy", 32'(busy[d]), 32'd0);
    end
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    // Known prior contents.
    do_req(0, 1'b1, 8'hFF, 8'h11, 0, 0);
    do_req(0, 1'b1, 8'h05, 8'h55, 0, 0);
    do_req(0, 1'b1, 8'h20, 8'hB0, 0, 0);
    do_req(0, 1'b1, 8'h21, 8'hB1, 0, 0);
    do_req(0, 1'b1, 8'h00, 8'hD0, 0, 0);
    do_req(0, 1'b1, 8'h01, 8'hD1, 0, 0);

    // Write A5 to 10, then read it back and check Mem_Out is held.
    do_req(0, 1'b1, 8'h10, 8'hA5, 0, 0);
    @(negedge Clock);
    chk("idle_after_access", 32'(busy[0]), 32'd0);
    do_req(0, 1'b0, 8'h10, 8'h00, 0, 0);
    repeat (3) @(negedge Clock);
    chk("read_value_held", 32'(mout[0]), 32'hA5);

    // Abort: Mem_CS released one cycle after capturing a write of 3C to FF.
    @(negedge Clock);
    cs[0] = 1'b0; wr[0] = 1'b1; addr[0] = 8'hFF; din[0] = 8'h3C;
    @(negedge Clock);
    chk("busy_in_wait", 32'(busy[0]), 32'd1);
    cs[0] = 1'b1;
    @(negedge Clock);
    chk("abort_to_idle", 32'(busy[0]), 32'd0);
    repeat (4) @(negedge Clock);
    do_req(0, 1'b0, 8'hFF, 8'h00, 0, 0);

    // Back-to-back reads of 00 and 01 with Mem_CS held low.
    do_req(0, 1'b0, 8'h00, 8'h00, 1, 0);
    do_req(0, 1'b0, 8'h01, 8'h00, 0, 0);
    @(negedge Clock);
    #1;
    chk("b2b_ready_spacing", rdy_cyc[0] - prev_rdy[0], 32'(ws_of(0) + 2));

    // Request inputs change after capture: read of 20, write of 6E to 30.
    do_req(0, 1'b0, 8'h20, 8'h00, 0, 1);
    do_req(0, 1'b1, 8'h30, 8'h6E, 0, 1);
    do_req(0, 1'b0, 8'h30, 8'h00, 0, 0);
    do_req(0, 1'b0, 8'h20, 8'h00, 0, 0);

    // Read immediately after a write to the same address.
    do_req(0, 1'b1, 8'h40, 8'h9E, 1, 0);
    do_req(0, 1'b0, 8'h40, 8'h00, 0, 0);

    // Asynchronous reset in the middle of WAIT of a write of 77 to 05.
    do_req(0, 1'b0, 8'h21, 8'h00, 0, 0);
    @(negedge Clock);
    cs[0] = 1'b0; wr[0] = 1'b1; addr[0] = 8'h05; din[0] = 8'h77;
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy[0]), 32'd0);
    chk("arst_ready", 32'(rdy[0]), 32'd0);
    chk("arst_mem_out", 32'(mout[0]), 32'h00);
    cs[0] = 1'b1;
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    do_req(0, 1'b0, 8'h05, 8'h00, 0, 0);

    // Randomised traffic over a small address window.
    for (int i = 0; i < 8; i++) do_req(0, 1'b1, 8'hC0 + 8'(i), 8'($urandom), 0, 0);
    for (int i = 0; i < 12; i++) begin
      ra = 8'hC0 + 8'($urandom_range(0, 7));
      rd = 8'($urandom);
      rw = 1'($urandom_range(0, 1));
      do_req(0, rw, ra, rd, (i != 11) && ($urandom_range(0, 1) == 1), 0);
    end
    cs[0] = 1'b1;

    // Zero-wait-state instance.
    do_req(1, 1'b1, 8'h33, 8'h5A, 0, 0);
    do_req(1, 1'b0, 8'h33, 8'h00, 0, 0);
    do_req(1, 1'b1, 8'h34, 8'h81, 1, 0);
    do_req(1, 1'b0, 8'h34, 8'h00, 1, 0);
    do_req(1, 1'b0, 8'h33, 8'h00, 0, 0);
    @(negedge Clock);
    #1;
    chk("ws0_b2b_spacing", rdy_cyc[1] - prev_rdy[1], 32'(ws_of(1) + 2));

    repeat (4) @(negedge Clock);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
